// File: rtl/selector_pkg.sv
// Shared definitions for the RTC set-mode field selector.
//   - Field codes driven on cambio_o (F_NONE = nothing selected).
//   - FSM state encoding (IDLE / EDIT).
//   - Helpers that step a field code forwards/backwards with wrap-around.
package selector_pkg;

    localparam int CAMBIO_W = 4;

    localparam logic [CAMBIO_W-1:0] F_NONE  = 4'd0;
    localparam logic [CAMBIO_W-1:0] F_SEG   = 4'd1;
    localparam logic [CAMBIO_W-1:0] F_MIN   = 4'd2;
    localparam logic [CAMBIO_W-1:0] F_HORA  = 4'd3;
    localparam logic [CAMBIO_W-1:0] F_DIA   = 4'd4;
    localparam logic [CAMBIO_W-1:0] F_MES   = 4'd5;
    localparam logic [CAMBIO_W-1:0] F_ANIO  = 4'd6;
    localparam logic [CAMBIO_W-1:0] F_THORA = 4'd7;
    localparam logic [CAMBIO_W-1:0] F_TMIN  = 4'd8;
    localparam logic [CAMBIO_W-1:0] F_TSEG  = 4'd9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EDIT = 1'b1;

    // Next field: the highest code wraps back to the first field.
    function automatic logic [CAMBIO_W-1:0] campo_sig(input logic [CAMBIO_W-1:0] campo,
                                                      input logic [CAMBIO_W-1:0] nf);
        if (campo >= nf) begin
            campo_sig = F_SEG;
        end else begin
            campo_sig = campo + 4'd1;
        end
    endfunction

    // Previous field: the first field wraps to the highest code.
    function automatic logic [CAMBIO_W-1:0] campo_ant(input logic [CAMBIO_W-1:0] campo,
                                                      input logic [CAMBIO_W-1:0] nf);
        if (campo <= F_SEG) begin
            campo_ant = nf;
        end else begin
            campo_ant = campo - 4'd1;
        end
    endfunction

endpackage

// File: rtl/selector_campo_antirrebote.sv
// antirrebote: two-flop synchroniser plus debounce for one raw push-button.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   raw_i    raw asynchronous button level
//   nivel_o  debounced level (registered)
//   flanco_o one-cycle pulse on a rising edge of nivel_o
// The debounced level only follows the synchronised input after it has
// differed from it for DEB_CYC consecutive cycles; any return to the current
// debounced value restarts the count.
module antirrebote #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic nivel_o,
    output logic flanco_o
);

    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          nivel_q;
    logic          prev_q;

    // Synchroniser, debounce counter and debounced level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            prev_q <= nivel_q;
            if (sync_q[1] != nivel_q) begin
                if (cnt_q == CNT_MAX) begin
                    nivel_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign nivel_o  = nivel_q;
    assign flanco_o = nivel_q & ~prev_q;

endmodule

// File: rtl/selector_campo.sv
// selector_campo: RTC set-mode front end. Debounces the four buttons and runs
// the IDLE/EDIT field-select FSM feeding the BCD number-entry stage.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   btn_set_i              enter / leave edit mode
//   btn_next_i, btn_prev_i step field code forwards / backwards (wrapping)
//   btn_up_i               held increment request
//   cambio_o               field code 0..N_FIELDS (0 = none), registered
//   aumenta_o              increment level, registered
//   editando_o             high while in EDIT
//   cambio_stb_o           one-cycle pulse whenever cambio_o changes
// Optional macro SEL_TIMEOUT_EN: leave EDIT after TIMEOUT_CYC cycles without
// a debounced button edge.
module selector_campo
    import selector_pkg::*;
#(
    parameter int DEB_CYC     = 500000,
    parameter int TIMEOUT_CYC = 500000000,
    parameter int N_FIELDS    = 9
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                btn_set_i,
    input  logic                btn_next_i,
    input  logic                btn_prev_i,
    input  logic                btn_up_i,
    output logic [CAMBIO_W-1:0] cambio_o,
    output logic                aumenta_o,
    output logic                editando_o,
    output logic                cambio_stb_o
);

    localparam logic [CAMBIO_W-1:0] NF = CAMBIO_W'(N_FIELDS);

    logic nivel_set_s, nivel_next_s, nivel_prev_s, nivel_up_s;
    logic set_f_s, next_f_s, prev_f_s, up_f_s;

    antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_set (
        .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(btn_set_i),
        .nivel_o(nivel_set_s), .flanco_o(set_f_s)
    );
    antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(btn_next_i),
        .nivel_o(nivel_next_s), .flanco_o(next_f_s)
    );
    antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_prev (
        .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(btn_prev_i),
        .nivel_o(nivel_prev_s), .flanco_o(prev_f_s)
    );
    antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_up (
        .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(btn_up_i),
        .nivel_o(nivel_up_s), .flanco_o(up_f_s)
    );

    // Only the edges of set/next/prev matter; their levels are intentionally unused.
    logic unused_s;
    assign unused_s = ^{nivel_set_s, nivel_next_s, nivel_prev_s};

    logic [0:0]          state_q, state_d;
    logic [CAMBIO_W-1:0] cambio_q, cambio_d;
    logic                aumenta_q, aumenta_d;
    logic                stb_q;
    logic                inhib_q, inhib_d;
    logic                chg_s;
    logic                timeout_s;

`ifdef SEL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_q, to_d;
    logic          actividad_s;

    assign actividad_s = set_f_s | next_f_s | prev_f_s | up_f_s;
    assign timeout_s   = (state_q == ST_EDIT) && (to_q == TO_MAX) && !actividad_s;

    // Inactivity counter: runs only in EDIT, cleared by any debounced edge.
    always_comb begin
        to_d = to_q;
        if ((state_q != ST_EDIT) || actividad_s || (to_q == TO_MAX)) begin
            to_d = '0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    // Inactivity counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Field-select FSM: set has priority, next+prev together cancel.
    always_comb begin
        state_d  = state_q;
        cambio_d = cambio_q;
        case (state_q)
            ST_IDLE: begin
                if (set_f_s) begin
                    state_d  = ST_EDIT;
                    cambio_d = F_SEG;
                end else begin
                    cambio_d = F_NONE;
                end
            end
            ST_EDIT: begin
                if (set_f_s || timeout_s) begin
                    state_d  = ST_IDLE;
                    cambio_d = F_NONE;
                end else if (next_f_s && !prev_f_s) begin
                    cambio_d = campo_sig(cambio_q, NF);
                end else if (prev_f_s && !next_f_s) begin
                    cambio_d = campo_ant(cambio_q, NF);
                end else begin
                    cambio_d = cambio_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cambio_d = F_NONE;
            end
        endcase
    end

    assign chg_s = (cambio_d != cambio_q);

    // Increment gating: a field change while up is held blocks aumenta until
    // up is released and pressed again (a fresh rising edge clears the block).
    always_comb begin
        inhib_d = inhib_q;
        if (chg_s && nivel_up_s) begin
            inhib_d = 1'b1;
        end else if (up_f_s) begin
            inhib_d = 1'b0;
        end else begin
            inhib_d = inhib_q;
        end
        aumenta_d = nivel_up_s && (state_q == ST_EDIT) && !chg_s && !inhib_d;
    end

    // State, field code, increment level and change strobe registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cambio_q  <= F_NONE;
            aumenta_q <= 1'b0;
            stb_q     <= 1'b0;
            inhib_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cambio_q  <= cambio_d;
            aumenta_q <= aumenta_d;
            stb_q     <= chg_s;
            inhib_q   <= inhib_d;
        end
    end

    assign cambio_o     = cambio_q;
    assign aumenta_o    = aumenta_q;
    assign editando_o   = (state_q == ST_EDIT);
    assign cambio_stb_o = stb_q;

endmodule

// File: tb/tb_selector_campo.sv
module tb_selector_campo;

    logic       clk;
    logic       rst_n;
    logic       b_set, b_next, b_prev, b_up;
    logic [3:0] cambio;
    logic       aumenta, editando, stb;

    int checks = 0;
    int errors = 0;

    selector_campo #(.DEB_CYC(4), .TIMEOUT_CYC(50), .N_FIELDS(9)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .btn_set_i(b_set), .btn_next_i(b_next), .btn_prev_i(b_prev), .btn_up_i(b_up),
        .cambio_o(cambio), .aumenta_o(aumenta), .editando_o(editando), .cambio_stb_o(stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise the buttons in m (bit0 set, 1 next, 2 prev, 3 up) for hi cycles, drop them,
    // idle for lo cycles; counts strobe pulses seen.
    task automatic drive(input logic [3:0] m, input int hi, input int lo, output int nstb);
        nstb = 0;
        @(negedge clk);
        if (m[0]) b_set = 1'b1;
        if (m[1]) b_next = 1'b1;
        if (m[2]) b_prev = 1'b1;
        if (m[3]) b_up = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(posedge clk); #1;
            if (stb) nstb++;
        end
        @(negedge clk);
        if (m[0]) b_set = 1'b0;
        if (m[1]) b_next = 1'b0;
        if (m[2]) b_prev = 1'b0;
        if (m[3]) b_up = 1'b0;
        for (int i = 0; i < lo; i++) begin
            @(posedge clk); #1;
            if (stb) nstb++;
        end
    endtask

    task automatic test_reset;
        b_set = 1'b0; b_next = 1'b0; b_prev = 1'b0; b_up = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cambio, aumenta, editando, stb} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000", {cambio, aumenta, editando, stb});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_enter;
        @(negedge clk);
        b_set = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (cambio !== ((i >= 7) ? 4'd1 : 4'd0) || stb !== (i == 7)) begin
                errors++;
                $display("FAIL enter_cycle%0d: cambio=%0d stb=%b required cambio=%0d stb=%b",
                         i, cambio, stb, (i >= 7) ? 1 : 0, (i == 7));
            end
        end
        @(negedge clk);
        b_set = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (editando !== 1'b1 || cambio !== 4'd1) begin
            errors++;
            $display("FAIL enter_state: editando=%b cambio=%0d required 1 1", editando, cambio);
        end
    endtask

    task automatic test_bounce_and_step;
        int n;
        int seen;
        seen = 0;
        for (int r = 0; r < 5; r++) begin
            drive(4'b0001, 2, 1, n);
            seen += n;
        end
        drive(4'b0000, 0, 8, n);
        seen += n;
        checks++;
        if (cambio !== 4'd1 || seen != 0) begin
            errors++;
            $display("FAIL set_bounce: cambio=%0d stb_count=%0d required 1 0", cambio, seen);
        end
        for (int k = 1; k <= 9; k++) begin
            drive(4'b0010, 8, 10, n);
            checks++;
            if (cambio !== 4'((k % 9) + 1) || n != 1) begin
                errors++;
                $display("FAIL next_%0d: cambio=%0d stb_count=%0d required %0d 1", k, cambio, n, (k % 9) + 1);
            end
        end
        drive(4'b0100, 8, 10, n);
        checks++;
        if (cambio !== 4'd9 || n != 1) begin
            errors++;
            $display("FAIL prev_wrap: cambio=%0d stb_count=%0d required 9 1", cambio, n);
        end
        for (int k = 0; k < 3; k++) drive(4'b0010, 8, 10, n);
        checks++;
        if (cambio !== 4'd3) begin
            errors++;
            $display("FAIL to_field3: cambio=%0d required 3", cambio);
        end
    endtask

    task automatic test_aumenta;
        int n;
        @(negedge clk);
        b_up = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            checks++;
            if (aumenta !== (i >= 7)) begin
                errors++;
                $display("FAIL up_hold_cycle%0d: aumenta=%b required %b", i, aumenta, (i >= 7));
            end
        end
        drive(4'b0010, 8, 10, n);
        checks++;
        if (cambio !== 4'd4 || aumenta !== 1'b0 || b_up !== 1'b1) begin
            errors++;
            $display("FAIL up_spill: cambio=%0d aumenta=%b required 4 0", cambio, aumenta);
        end
        @(negedge clk);
        b_up = 1'b0;
        repeat (10) @(posedge clk);
        drive(4'b1000, 9, 10, n);
        checks++;
        if (aumenta !== 1'b0) begin
            errors++;
            $display("FAIL up_released: aumenta=%b required 0", aumenta);
        end
        @(negedge clk);
        b_up = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (aumenta !== 1'b1) begin
            errors++;
            $display("FAIL up_repress: aumenta=%b required 1", aumenta);
        end
        @(negedge clk);
        b_up = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_simultaneous;
        int n;
        drive(4'b0110, 8, 10, n);
        checks++;
        if (cambio !== 4'd4 || n != 0) begin
            errors++;
            $display("FAIL next_prev_cancel: cambio=%0d stb_count=%0d required 4 0", cambio, n);
        end
        drive(4'b0011, 8, 10, n);
        checks++;
        if (cambio !== 4'd0 || editando !== 1'b0 || n != 1) begin
            errors++;
            $display("FAIL set_beats_next: cambio=%0d editando=%b stb_count=%0d required 0 0 1",
                     cambio, editando, n);
        end
    endtask

    task automatic test_reset_mid_edit;
        int n;
        drive(4'b0001, 8, 10, n);
        @(negedge clk);
        b_up = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (aumenta !== 1'b1 || editando !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: aumenta=%b editando=%b required 1 1", aumenta, editando);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cambio, aumenta, editando, stb} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0000000", {cambio, aumenta, editando, stb});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (aumenta !== 1'b0 || editando !== 1'b0 || cambio !== 4'd0) begin
            errors++;
            $display("FAIL after_reset_up_held: aumenta=%b editando=%b cambio=%0d required 0 0 0",
                     aumenta, editando, cambio);
        end
        @(negedge clk);
        b_up = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic enter_edit(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        b_set = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (stb) ok = 1'b1;
        end
        b_set = 1'b0;
        checks++;
        if (!ok || cambio !== 4'd1) begin
            errors++;
            $display("FAIL enter_edit_wait: seen=%b cambio=%0d required 1 1", ok, cambio);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        enter_edit(ok);
`ifdef SEL_TIMEOUT_EN
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (i == 49 || i == 50) begin
                checks++;
                if (cambio !== ((i == 50) ? 4'd0 : 4'd1) || stb !== (i == 50)) begin
                    errors++;
                    $display("FAIL timeout_cycle%0d: cambio=%0d stb=%b required %0d %b",
                             i, cambio, stb, (i == 50) ? 0 : 1, (i == 50));
                end
            end
        end
        repeat (10) @(posedge clk);
        enter_edit(ok);
        for (int i = 1; i <= 99; i++) begin
            if (i == 43) begin
                @(negedge clk);
                b_up = 1'b1;
            end
            @(posedge clk); #1;
            if (i == 50 || i == 98 || i == 99) begin
                checks++;
                if (cambio !== ((i == 99) ? 4'd0 : 4'd1)) begin
                    errors++;
                    $display("FAIL timeout_restart_cycle%0d: cambio=%0d required %0d",
                             i, cambio, (i == 99) ? 0 : 1);
                end
            end
        end
        @(negedge clk);
        b_up = 1'b0;
        repeat (10) @(posedge clk);
`else
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (cambio !== 4'd1 || editando !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: cambio=%0d editando=%b required 1 1", cambio, editando);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_enter;
        test_bounce_and_step;
        test_aumenta;
        test_simultaneous;
        test_reset_mid_edit;
        test_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
